// File: rtl/alu_pkg.sv
// alu_pkg -- shared types and width helpers for the iterative ALU.
//   opcode_e : command encoding on opcode_i (Nop/Add/Mul/Div).
//   state_e  : top-level control FSM states.
//   res_width: result width for a given operand width.
package alu_pkg;

    typedef enum logic [1:0] {
        Nop = 2'd0,
        Add = 2'd1,
        Mul = 2'd2,
        Div = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Busy = 2'd1,
        Fix  = 2'd2,
        Done = 2'd3
    } state_e;

    // Results carry a full product or {remainder, quotient}.
    function automatic int res_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// alu_muldiv_core -- shared one-bit-per-cycle multiply / restoring-divide
// datapath working on unsigned magnitudes.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : load magnitudes and arm WidthP iterations
//   is_div_i       : select divide (1) or multiply (0) for this run
//   mag_a_i        : multiplicand / dividend magnitude
//   mag_b_i        : multiplier / divisor magnitude
//   last_o         : the iteration on the coming edge is the final one
//   hi_o, lo_o     : mul -> product {hi,lo}; div -> remainder hi, quotient lo
module alu_muldiv_core #(
    parameter int WidthP = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              is_div_i,
    input  logic [WidthP-1:0] mag_a_i,
    input  logic [WidthP-1:0] mag_b_i,
    output logic              last_o,
    output logic [WidthP-1:0] hi_o,
    output logic [WidthP-1:0] lo_o
);
    localparam int CntW = $clog2(WidthP + 1);

    logic [WidthP-1:0] hi_q, hi_d;   // product high half / partial remainder
    logic [WidthP-1:0] lo_q, lo_d;   // multiplier shifting out / quotient shifting in
    logic [WidthP-1:0] m_q;          // multiplicand / divisor
    logic              div_q;
    logic [CntW-1:0]   cnt_q;

    logic [WidthP:0] sum, shl, diff;
    logic            ge;

    always_comb begin
        // Multiply: conditionally add, keep the carry, shift the pair right.
        sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : '0)};
        // Divide: shift the next dividend bit into the remainder, trial subtract.
        // The remainder stays below the divisor, so shl fits in WidthP+1 bits.
        shl  = {hi_q, lo_q[WidthP-1]};
        diff = shl - {1'b0, m_q};
        ge   = (shl >= {1'b0, m_q});
        if (div_q) begin
            hi_d = ge ? diff[WidthP-1:0] : shl[WidthP-1:0];
            lo_d = {lo_q[WidthP-2:0], ge};
        end else begin
            {hi_d, lo_d} = {sum, lo_q[WidthP-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= is_div_i ? mag_a_i : mag_b_i;
            m_q   <= is_div_i ? mag_b_i : mag_a_i;
            div_q <= is_div_i;
            cnt_q <= CntW'(WidthP);
        end else if (cnt_q != '0) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign last_o = (cnt_q == CntW'(1));
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_iter.sv
// alu_iter -- signed Add / Mul / Div ALU with valid/ready handshakes.
// Mul and Div run WidthP iterations in alu_muldiv_core, then a Fix cycle
// applies sign correction and divide special cases.
//   clk_i, reset_i           : clock, synchronous active-high reset
//   valid_i, ready_o         : command handshake
//   opcode_i                 : Nop=0, Add=1, Mul=2, Div=3
//   operand_a_i, operand_b_i : signed operands (dividend, divisor for Div)
//   valid_o, ready_i         : result handshake
//   result_o                 : 2*WidthP result, held while valid_o=1
// Build option ALU_ITER_BACK_TO_BACK_EN: accept a new command in the same
// cycle the result is taken (ready_o also high in Done when ready_i=1).
module alu_iter
    import alu_pkg::*;
#(
    parameter int WidthP = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   valid_i,
    input  logic [1:0]             opcode_i,
    input  logic [WidthP-1:0]      operand_a_i,
    input  logic [WidthP-1:0]      operand_b_i,
    output logic                   ready_o,
    input  logic                   ready_i,
    output logic [2*WidthP-1:0]    result_o,
    output logic                   valid_o
);
    localparam int ResW = res_width(WidthP);

    state_e            state_q, state_d;
    opcode_e           op_q, op_in;
    logic              neg_a_q, neg_b_q, b_zero_q;
    logic [WidthP-1:0] a_q;
    logic [ResW-1:0]   result_q, result_d;
    logic              accept, start;

    logic [WidthP-1:0] mag_a, mag_b;
    logic [WidthP:0]   sum;
    logic              core_last;
    logic [WidthP-1:0] core_hi, core_lo;
    logic [ResW-1:0]   prod, mul_res, div_res;
    logic [WidthP-1:0] quo, rem;

`ifdef ALU_ITER_BACK_TO_BACK_EN
    assign ready_o = ~reset_i & ((state_q == Idle) | ((state_q == Done) & ready_i));
`else
    assign ready_o = ~reset_i & (state_q == Idle);
`endif

    assign accept = valid_i & ready_o;
    assign op_in  = opcode_e'(opcode_i);

    // Negating the most-negative value yields 2^(WidthP-1), which is exact
    // when the bits are read as unsigned.
    assign mag_a = operand_a_i[WidthP-1] ? -operand_a_i : operand_a_i;
    assign mag_b = operand_b_i[WidthP-1] ? -operand_b_i : operand_b_i;
    assign sum   = {operand_a_i[WidthP-1], operand_a_i} + {operand_b_i[WidthP-1], operand_b_i};

    alu_muldiv_core #(.WidthP(WidthP)) u_core (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .start_i  (start),
        .is_div_i (op_in == Div),
        .mag_a_i  (mag_a),
        .mag_b_i  (mag_b),
        .last_o   (core_last),
        .hi_o     (core_hi),
        .lo_o     (core_lo)
    );

    // Sign fix-up. MostNeg / -1 needs no special case: the magnitude
    // quotient 2^(WidthP-1) with positive sign already reads as MostNeg.
    assign prod    = {core_hi, core_lo};
    assign mul_res = (neg_a_q ^ neg_b_q) ? -prod : prod;
    assign quo     = (neg_a_q ^ neg_b_q) ? -core_lo : core_lo;
    assign rem     = neg_a_q ? -core_hi : core_hi;
    assign div_res = b_zero_q ? {a_q, {WidthP{1'b1}}} : {rem, quo};

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        start    = 1'b0;
        case (state_q)
            Busy:    if (core_last) state_d = Fix;
            Fix: begin
                result_d = (op_q == Div) ? div_res : mul_res;
                state_d  = Done;
            end
            Done:    if (ready_i) state_d = Idle;
            default: ;
        endcase
        // Accept is only possible in Idle, or in Done alongside the result
        // handshake, so it overrides the transitions above.
        if (accept) begin
            case (op_in)
                Nop: begin
                    result_d = '0;
                    state_d  = Done;
                end
                Add: begin
                    result_d = {{(WidthP-1){sum[WidthP]}}, sum};
                    state_d  = Done;
                end
                default: begin
                    start   = 1'b1;
                    state_d = Busy;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= Idle;
            result_q <= '0;
            op_q     <= Nop;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            if (accept) begin
                op_q     <= op_in;
                neg_a_q  <= operand_a_i[WidthP-1];
                neg_b_q  <= operand_b_i[WidthP-1];
                b_zero_q <= (operand_b_i == '0);
                a_q      <= operand_a_i;
            end
        end
    end

    assign valid_o  = (state_q == Done);
    assign result_o = result_q;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          valid_i;
    logic [1:0]    opcode_i;
    logic [W-1:0]  operand_a_i, operand_b_i;
    logic          ready_o;
    logic          ready_i;
    logic [2*W-1:0] result_o;
    logic          valid_o;

    int checks   = 0;
    int failures = 0;
    logic [63:0] sb_q[$];

    alu_iter #(.WidthP(W)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .valid_i     (valid_i),
        .opcode_i    (opcode_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .ready_o     (ready_o),
        .ready_i     (ready_i),
        .result_o    (result_o),
        .valid_o     (valid_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed 64-bit arithmetic, truncating division.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: return 64'd0;
            2'd1: return 64'(sa + sb);
            2'd2: return 64'(sa * sb);
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Drive one command, push its expected result, then measure the latency
    // (edges counted from the accept edge) and compare on valid_o.
    task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        bit saw_rdy;
        logic [63:0] e;
        n = 0;
        while (!ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
        chk({tag, " ready_o before issue"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; opcode_i = op; operand_a_i = a; operand_b_i = b;
        sb_q.push_back(exp);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        operand_a_i = $urandom; operand_b_i = $urandom; opcode_i = 2'($urandom);
        n = 1; saw_rdy = 1'b0;
        while (!valid_o && n < 200) begin
            if (ready_o) saw_rdy = 1'b1;
            @(posedge clk_i); #1; n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(lat));
        chk({tag, " ready_o low while busy"}, 64'(saw_rdy), 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, " scoreboard nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, " result"}, result_o, e);
        end
        if (ready_i) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        logic [63:0] held;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset_i = 1'b1; valid_i = 1'b0; opcode_i = 2'd0;
        operand_a_i = '0; operand_b_i = '0; ready_i = 1'b1;

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset valid_o", 64'(valid_o), 64'd0);
        chk("reset result_o", result_o, 64'd0);
        chk("reset ready_o", 64'(ready_o), 64'd0);
        reset_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ready_o after reset", 64'(ready_o), 64'd1);

        // Directed cases with fixed expected values.
        issue("add max+1", 2'd1, 32'h7FFF_FFFF, 32'h0000_0001, 64'h0000_0000_8000_0000, 1);
        issue("add -1+1", 2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0, 1);
        issue("nop", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0, 1);
        issue("mul -3*7", 2'd2, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, W + 2);
        issue("mul minneg^2", 2'd2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, W + 2);
        issue("div 7/-2", 2'd3, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, W + 2);
        issue("div -7/2", 2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, W + 2);
        issue("div overflow", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, W + 2);
        issue("div by zero", 2'd3, 32'h0000_0005, 32'h0, 64'h0000_0005_FFFF_FFFF, W + 2);

        // Random cases against the reference.
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(1, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'h0 : $urandom;
            issue($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, model(rop, ra, rb),
                  (rop == 2'd1) ? 1 : W + 2);
        end

        // Backpressure: result must hold, extra command ignored.
        ready_i = 1'b0;
        issue("bp add", 2'd1, 32'd10, 32'd20, 64'd30, 1);
        held = result_o;
        for (int k = 0; k < 5; k++) begin
            valid_i = (k == 2); opcode_i = 2'd1; operand_a_i = 32'd1; operand_b_i = 32'd1;
            chk($sformatf("bp ready_o c%0d", k), 64'(ready_o), 64'd0);
            @(posedge clk_i); #1;
            chk($sformatf("bp valid_o c%0d", k), 64'(valid_o), 64'd1);
            chk($sformatf("bp result c%0d", k), result_o, held);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp released", 64'(valid_o), 64'd0);
        repeat (3) begin
            @(posedge clk_i); #1;
            chk("bp ignored cmd no result", 64'(valid_o), 64'd0);
        end

        // Reset in the middle of a multiply.
        chk("mid-reset ready_o", 64'(ready_o), 64'd1);
        valid_i = 1'b1; opcode_i = 2'd2; operand_a_i = 32'd1234; operand_b_i = 32'd5678;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        chk("mid-reset valid_o", 64'(valid_o), 64'd0);
        chk("mid-reset result_o", result_o, 64'd0);
        reset_i = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk_i); #1;
            if (valid_o) break;
        end
        chk("aborted mul no result", 64'(valid_o), 64'd0);
        issue("add 2+3 after reset", 2'd1, 32'd2, 32'd3, 64'd5, 1);

        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
